// File: rtl/ft245_sample_tx.sv
// ft245_sample_tx: buffers tagged 12-bit ADC samples and streams
// each one as two bytes over an FT245-style write-only FIFO bus.
module ft245_sample_tx #(
  parameter int DEPTH      = 16,
  parameter int WR_CYCLES  = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [11:0]            s_data,
  input  logic                   s_first,
  input  logic                   ft_txe,
  output logic [7:0]             ft_d_out,
  output logic                   ft_d_oe,
  output logic                   ft_wr,
  output logic                   ft_rd,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } state_t;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          gap_last;

  logic [1:0]    txe_sync;
  logic          txe_s;

  state_t        state;
  logic          byte_sel;
  logic [7:0]    cnt;
  logic [12:0]   head;
  logic [7:0]    head_byte;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign txe_s = txe_sync[1];

  // The head is only retired after its low byte has gone out.
  assign gap_last = (state == GAP) &&
                    (cnt == 8'(GAP_CYCLES - 1));
  assign pop  = gap_last && byte_sel;
  assign push = s_valid && (!full || pop);
  assign drop = s_valid && full && !pop;

  // Bit 7 of the high byte carries the frame flag for host resync.
  assign head      = mem[rd_ptr];
  assign head_byte = byte_sel ? head[7:0]
                              : {head[12], 3'b000, head[11:8]};

  assign ft_rd      = 1'b1;
  assign fifo_level = level;

  // Sample storage; stale contents are harmless once pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_first, s_data};
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (push && !pop): level <= level + 1'b1;
        (pop && !push): level <= level - 1'b1;
        default:        level <= level;
      endcase
    end
  end

  // Sticky drop flag and saturating drop counter; a clear in the
  // same cycle as a drop still records that drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_overflow) begin
      overflow   <= drop;
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Two-flop synchroniser; idles as "no space" out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      txe_sync <= 2'b11;
    end else begin
      txe_sync <= {txe_sync[0], ft_txe};
    end
  end

  // Byte write sequencer with registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_sel <= 1'b0;
      cnt      <= '0;
      ft_wr    <= 1'b0;
      ft_d_oe  <= 1'b0;
      ft_d_out <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty && !txe_s) begin
            state    <= SETUP;
            ft_d_oe  <= 1'b1;
            ft_d_out <= head_byte;
          end
        end
        SETUP: begin
          state <= STROBE;
          ft_wr <= 1'b1;
          cnt   <= '0;
        end
        STROBE: begin
          if (cnt == 8'(WR_CYCLES - 1)) begin
            state <= GAP;
            ft_wr <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_last) begin
            state    <= IDLE;
            ft_d_oe  <= 1'b0;
            byte_sel <= ~byte_sel;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_sample_tx.sv
// tb_ft245_sample_tx: scoreboard bench; expected bytes are queued
// at push time and checked by a monitor on each WR falling edge.
module tb_ft245_sample_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_first = 1'b0;
  logic        ft_txe = 1'b0;
  logic        clr_overflow = 1'b0;
  logic [7:0]  ft_d_out;
  logic        ft_d_oe;
  logic        ft_wr;
  logic        ft_rd;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int rise_q[$];
  int rise_cnt = 0;
  int fall_cnt = 0;
  int fall_cyc = 0;
  int hi_len = 0;
  logic prev_wr = 1'b0;

  ft245_sample_tx dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_first      (s_first),
    .ft_txe       (ft_txe),
    .ft_d_out     (ft_d_out),
    .ft_d_oe      (ft_d_oe),
    .ft_wr        (ft_wr),
    .ft_rd        (ft_rd),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_count   (drop_count)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse width, byte order and bus sanity.
  always @(negedge clk) begin
    if (rst) begin
      hi_len = 0;
    end else begin
      chk("ft_rd_high", ft_rd, 1);
      if (ft_wr) begin
        hi_len++;
        chk("oe_during_wr", ft_d_oe, 1);
        if (!prev_wr) begin
          rise_q.push_back(cyc);
          rise_cnt++;
        end
      end else if (prev_wr) begin
        fall_cnt++;
        fall_cyc = cyc;
        chk("wr_width", hi_len, 3);
        hi_len = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL byte: got %02h want none", ft_d_out);
        end else begin
          chk("byte", ft_d_out, exp_q.pop_front());
        end
      end
    end
    prev_wr = ft_wr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic f,
                      input logic [11:0] d,
                      input bit keep);
    s_valid = 1'b1;
    s_first = f;
    s_data  = d;
    if (keep) begin
      exp_q.push_back({f, 3'b000, d[11:8]});
      exp_q.push_back(d[7:0]);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && fifo_level == 0 &&
                 !ft_wr && !ft_d_oe) && n < budget);
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, queue=%0d level=%0d",
               name, exp_q.size(), fifo_level);
    end
    tick();
  endtask

  task automatic wait_rise(input int target, input string name);
    int n;
    n = 0;
    while (rise_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rise_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: no strobe, got %0d want %0d",
               name, rise_cnt, target);
    end
  endtask

  task automatic wait_fall(input int target, input string name);
    int n;
    n = 0;
    while (fall_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (fall_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: no fall, got %0d want %0d",
               name, fall_cnt, target);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int c;
    int rn;
    int fc;
    int f;
    int n;

    // Reset values
    repeat (3) tick();
    chk("rst_wr", ft_wr, 0);
    chk("rst_oe", ft_d_oe, 0);
    chk("rst_dout", ft_d_out, 8'h00);
    chk("rst_rd", ft_rd, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);
    rst = 1'b0;
    repeat (4) tick();

    // Single sample: 0x8A then 0xBC
    c  = cyc;
    rn = rise_cnt;
    push(1'b1, 12'hABC, 1'b1);
    wait_idle(100, "single_done");
    if (rise_q.size() >= rn + 2) begin
      chk("first_latency", rise_q[rn] - c, 3);
      chk("strobe_spacing", rise_q[rn+1] - rise_q[rn], 9);
    end else begin
      total++;
      bad++;
      $display("FAIL single_rises: got %0d want 2",
               rise_q.size() - rn);
    end
    chk("single_level", fifo_level, 0);

    // Back-pressure between the two bytes
    rn = rise_cnt;
    fc = fall_cnt;
    push(1'b0, 12'h123, 1'b1);
    wait_fall(fc + 1, "bp_first");
    ft_txe = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_no_wr", rise_cnt, rn + 1);
    chk("bp_level", fifo_level, 1);
    chk("bp_oe_low", ft_d_oe, 0);
    tick();
    c = cyc;
    ft_txe = 1'b0;
    wait_rise(rn + 2, "bp_resume");
    if (rise_q.size() >= rn + 2) begin
      chk("bp_resume_lat", rise_q[rn+1] - c, 4);
    end
    wait_idle(100, "bp_done");

    // Overflow with TXE held high
    ft_txe = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      push(i == 0, 12'(12'h200 + i * 19), i < 16);
    end
    tick();
    chk("ovf_level", fifo_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 4);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_drops", drop_count, 0);

    // Clear coinciding with a drop
    clr_overflow = 1'b1;
    push(1'b0, 12'hFFF, 1'b0);
    clr_overflow = 1'b0;
    chk("clrdrop_flag", overflow, 1);
    chk("clrdrop_drops", drop_count, 1);
    chk("clrdrop_level", fifo_level, 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr2_drops", drop_count, 0);

    // Full FIFO: push aligned with the first pop
    fc = fall_cnt;
    ft_txe = 1'b0;
    wait_fall(fc + 2, "full_low_byte");
    f = fall_cyc;
    n = 0;
    tick();
    while (cyc < f + 3 && n < 10) begin
      tick();
      n++;
    end
    chk("align_cycle", cyc, f + 3);
    push(1'b1, 12'hFED, 1'b1);
    chk("pushpop_level", fifo_level, 16);
    chk("pushpop_drops", drop_count, 0);
    chk("pushpop_flag", overflow, 0);
    wait_idle(800, "drain_done");

    // Reset during the second STROBE cycle
    rn = rise_cnt;
    push(1'b1, 12'h5A5, 1'b0);
    wait_rise(rn + 1, "rst_strobe");
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_wr", ft_wr, 0);
    chk("midrst_oe", ft_d_oe, 0);
    chk("midrst_level", fifo_level, 0);
    tick();
    rst = 1'b0;
    tick();
    rn = rise_cnt;
    push(1'b0, 12'h3C7, 1'b1);
    wait_idle(100, "post_rst_done");
    chk("post_rst_strobes", rise_cnt - rn, 2);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
